// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and helpers used by every layer.
package cnn_pkg;

  localparam int CNN_W   = 18;
  localparam int SAT_MAX = (1 << (CNN_W - 1)) - 1;   //  131071
  localparam int SAT_MIN = -(1 << (CNN_W - 1));      // -131072

  // Clamp a wide signed value into the signed range of a w-bit result.
  // Callers keep the low w bits of the return value.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] v,
                                               input int                 w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

  // Bit offset of lane i in a flat vector of w-bit lanes (lane 0 at the LSBs).
  function automatic int lane_lsb(input int i, input int w);
    return i * w;
  endfunction

endpackage

// File: rtl/bias_accum_lane.sv
// One lane: bias-seeded partial-sum accumulator with ReLU and saturation
// into a held output register.
module bias_accum_lane
  import cnn_pkg::*;
#(
  parameter int W     = CNN_W,
  parameter int ACC_W = W + 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fire_i,     // beat accepted this cycle
  input  logic         first_i,    // accepted beat is the first of a vector
  input  logic         last_i,     // accepted beat is the final one
  input  logic         relu_en_i,
  input  logic [W-1:0] bias_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o
);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic        [W-1:0]     out_q, out_d;
  logic signed [ACC_W-1:0] bias_x, din_x, sum, relu_v;
  logic signed [63:0]      wide, sat64;
  logic                    sat_hi_unused;

  // Bias only enters on the first beat, so later bias changes are ignored.
  // With a single-beat vector first and last coincide and the same sum works.
  always_comb begin
    bias_x = {{(ACC_W-W){bias_i[W-1]}}, bias_i};
    din_x  = {{(ACC_W-W){din_i[W-1]}}, din_i};
    sum    = (first_i ? bias_x : acc_q) + din_x;
    relu_v = (relu_en_i && sum[ACC_W-1]) ? '0 : sum;
    wide   = {{(64-ACC_W){relu_v[ACC_W-1]}}, relu_v};
    sat64  = sat_w(wide, W);
    acc_d  = fire_i ? sum : acc_q;
    out_d  = (fire_i && last_i) ? sat64[W-1:0] : out_q;
  end

  assign sat_hi_unused = ^sat64[63:W];

  // Accumulator and held result; reset drops any partial or pending vector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      out_q <= '0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

  assign dout_o = out_q;

endmodule

// File: rtl/bias_accum_relu.sv
// Per-channel bias fold, N_SLICES-beat accumulation, ReLU and saturation
// with a valid/ready output register toward the next layer's buffer.
module bias_accum_relu
  import cnn_pkg::*;
#(
  parameter int N_adder_tree = 16,
  parameter int W            = CNN_W,
  parameter int N_SLICES     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_adder_tree*W-1:0] bias,
  input  logic                      relu_en,
  input  logic [N_adder_tree*W-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [N_adder_tree*W-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(N_SLICES):0] slice_cnt
);

  localparam int ACC_W = W + $clog2(N_SLICES + 1) + 1;
  localparam int CW    = $clog2(N_SLICES) + 1;
  localparam logic [CW-1:0] LAST = CW'(N_SLICES - 1);

  logic [N_adder_tree-1:0][W-1:0] bias_l, in_l, out_l;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vld_q, vld_d;
  logic          is_first, is_last, fire;

  assign bias_l   = bias;
  assign in_l     = in_data;
  assign out_data = out_l;

  assign is_first = (cnt_q == '0);
  assign is_last  = (cnt_q == LAST);
  // Only a final beat can stall, and only behind an unaccepted result.
  assign in_ready = !is_last || !vld_q || out_ready;
  assign fire     = in_valid && in_ready;

  // Beat counter and output-valid next state.
  always_comb begin
    cnt_d = cnt_q;
    vld_d = vld_q;
    if (fire) cnt_d = is_last ? '0 : cnt_q + CW'(1);
    if (fire && is_last) vld_d = 1'b1;
    else if (out_ready)  vld_d = 1'b0;
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

  for (genvar g = 0; g < N_adder_tree; g++) begin : g_lane
    bias_accum_lane #(.W(W), .ACC_W(ACC_W)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .fire_i    (fire),
      .first_i   (is_first),
      .last_i    (is_last),
      .relu_en_i (relu_en),
      .bias_i    (bias_l[g]),
      .din_i     (in_l[g]),
      .dout_o    (out_l[g])
    );
  end

  assign out_valid = vld_q;
  assign slice_cnt = cnt_q;

endmodule

// File: tb/tb_bias_accum_relu.sv
// Directed test of bias_accum_relu with hand-computed expectations.
module tb_bias_accum_relu;
  localparam int N  = 16;
  localparam int W  = 18;
  localparam int NS = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0][W-1:0] bias_v, in_v, out_v;
  logic relu_en, in_valid, in_ready, out_valid, out_ready;
  logic [$clog2(NS):0] slice_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bias_accum_relu #(.N_adder_tree(N), .W(W), .N_SLICES(NS)) dut (
    .clk(clk), .rst_n(rst_n), .bias(bias_v), .relu_en(relu_en),
    .in_data(in_v), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_v), .out_valid(out_valid), .out_ready(out_ready),
    .slice_cnt(slice_cnt)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int lane(input int i);
    logic signed [W-1:0] v;
    v = out_v[i];
    return int'(v);
  endfunction

  // Present one beat; lane0/lane1/lane2 values, other lanes zero.
  task automatic drive(input int l0, input int l1, input int l2);
    in_v     = '0;
    in_v[0]  = W'(l0);
    in_v[1]  = W'(l1);
    in_v[2]  = W'(l2);
    in_valid = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; bias_v = '0; in_v = '0; relu_en = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data0", lane(0), 0);
    chk("rst_cnt",   int'(slice_cnt), 0);
    chk("rst_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    step();

    // Basic accumulation, relu off
    bias_v[0] = W'(1968); bias_v[2] = W'(-52940);
    drive(100, 0, 0); step(); chk("a_cnt1", int'(slice_cnt), 1);
    drive(200, 0, 0); step(); chk("a_cnt2", int'(slice_cnt), 2);
    drive(300, 0, 0); step(); chk("a_cnt3", int'(slice_cnt), 3);
    chk("a_novalid", int'(out_valid), 0);
    drive(400, 0, 0); step();
    chk("a_valid", int'(out_valid), 1);
    chk("a_lane0", lane(0), 2968);
    chk("a_lane1", lane(1), 0);
    chk("a_lane2", lane(2), -52940);
    chk("a_cnt0",  int'(slice_cnt), 0);
    in_valid = 1'b0; step();
    chk("a_pulse", int'(out_valid), 0);
    chk("a_hold",  lane(0), 2968);

    // ReLU on final beat; mid-vector bias change ignored
    drive(0, 0, 0); step();
    bias_v[0] = W'(999);
    drive(0, 0, 0); step();
    drive(0, 0, 0); step();
    relu_en = 1'b1;
    drive(0, 0, 0); step();
    chk("b_lane0", lane(0), 1968);
    chk("b_lane2", lane(2), 0);
    relu_en = 1'b0; in_valid = 1'b0; step();

    // Saturation both ways
    bias_v = '0; bias_v[0] = W'(131071); bias_v[1] = W'(-131072);
    for (int k = 0; k < NS; k++) begin drive(131071, -131072, 0); step(); end
    chk("s_max", lane(0), 131071);
    chk("s_min", lane(1), -131072);
    in_valid = 1'b0; step();

    // Backpressure
    bias_v = '0;
    for (int k = 0; k < NS; k++) begin drive(1, 0, 0); step(); end
    chk("p_v1", int'(out_valid), 1);
    chk("p_d1", lane(0), 4);
    out_ready = 1'b0;
    for (int k = 0; k < NS - 1; k++) begin drive(2, 0, 0); step(); end
    chk("p_cnt3", int'(slice_cnt), 3);
    drive(2, 0, 0); #1;
    chk("p_stall", int'(in_ready), 0);
    step(); step();
    chk("p_cnt_hold", int'(slice_cnt), 3);
    chk("p_data_hold", lane(0), 4);
    chk("p_vld_hold", int'(out_valid), 1);
    out_ready = 1'b1; #1;
    chk("p_release", int'(in_ready), 1);
    step();
    chk("p_v2", int'(out_valid), 1);
    chk("p_d2", lane(0), 8);
    chk("p_cnt0", int'(slice_cnt), 0);
    in_valid = 1'b0; step();
    chk("p_drop", int'(out_valid), 0);

    // Back-to-back, three vectors
    for (int c = 0; c < 3 * NS; c++) begin
      drive(c / NS + 1, 0, 0); #1;
      chk("bb_ready", int'(in_ready), 1);
      step();
      if (c % NS == NS - 1) begin
        chk("bb_valid", int'(out_valid), 1);
        chk("bb_data",  lane(0), 4 * (c / NS + 1));
      end
    end
    in_valid = 1'b0; step();

    // Reset mid-vector
    drive(777, 0, 0); step(); step();
    in_valid = 1'b0; rst_n = 1'b0; step();
    chk("r_cnt",   int'(slice_cnt), 0);
    chk("r_valid", int'(out_valid), 0);
    chk("r_data",  lane(0), 0);
    rst_n = 1'b1;
    bias_v[0] = W'(5);
    for (int k = 0; k < NS; k++) begin drive(10, 0, 0); step(); end
    chk("r_out", lane(0), 45);
    chk("r_vld", int'(out_valid), 1);
    in_valid = 1'b0; step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
